// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: central pipeline sequencer for the in-order RV32 core.
// One FSM (INIT/RUN/MC_WAIT/FLUSH) owns every stall, flush, bubble and
// PC-redirect decision so no pipeline stage computes its own hazards.
// Optional performance counters are built only when RV_PIPE_CTRL_PERF_EN
// is defined; otherwise both counter ports are tied to zero.
module rv_pipe_ctrl #(
    parameter int INIT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_imem_ready,
    input  logic [4:0]  i_dec_rs1,
    input  logic [4:0]  i_dec_rs2,
    input  logic        i_dec_rs1_use,
    input  logic        i_dec_rs2_use,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_load,
    input  logic        i_ex_mc_start,
    input  logic        i_ex_mc_done,
    input  logic        i_ex_redirect,
    input  logic [29:0] i_ex_target,
    input  logic        i_trap,
    input  logic [29:0] i_trap_vec,
    output logic        o_fetch_stall,
    output logic        o_dec_stall,
    output logic        o_dec_flush,
    output logic        o_ex_bubble,
    output logic        o_pc_load,
    output logic [29:0] o_pc_target,
    output logic        o_mc_abort,
    output logic [31:0] o_perf_stall_cnt,
    output logic [31:0] o_perf_flush_cnt
);

    // One shared counter covers the init window, the flush window and the
    // multicycle timeout; it is sized for the largest of the three.
    localparam int CMAX1 = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
    localparam int CMAX  = (CMAX1 > MC_TIMEOUT) ? CMAX1 : MC_TIMEOUT;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] INIT_LOAD  = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] MC_LAST    = CW'((MC_TIMEOUT > 0) ? MC_TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_MC_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [29:0]   pc_tgt_q, pc_tgt_d;
    logic [29:0]   load_tgt;
    logic          load_use;
    logic          mc_timeout;

    assign load_use = i_ex_load && (i_ex_rd != '0) &&
                      ((i_dec_rs1_use && (i_dec_rs1 == i_ex_rd)) ||
                       (i_dec_rs2_use && (i_dec_rs2 == i_ex_rd)));

    assign mc_timeout = (MC_TIMEOUT != 0) && (cnt_q == MC_LAST);

    // Next-state, counter and per-cycle pipeline control decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        load_tgt      = i_ex_target;
        o_fetch_stall = 1'b0;
        o_dec_stall   = 1'b0;
        o_dec_flush   = 1'b0;
        o_ex_bubble   = 1'b0;
        o_pc_load     = 1'b0;
        o_mc_abort    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (i_trap || i_ex_redirect) begin
                    o_pc_load   = 1'b1;
                    load_tgt    = i_trap ? i_trap_vec : i_ex_target;
                    o_dec_flush = 1'b1;
                    o_ex_bubble = 1'b1;
                    state_d     = ST_FLUSH;
                    cnt_d       = FLUSH_LOAD;
                end else if (i_ex_mc_start && !i_ex_mc_done) begin
                    o_fetch_stall = 1'b1;
                    o_dec_stall   = 1'b1;
                    state_d       = ST_MC_WAIT;
                    cnt_d         = '0;
                end else if (load_use || !i_imem_ready) begin
                    o_fetch_stall = 1'b1;
                    o_dec_stall   = 1'b1;
                    o_ex_bubble   = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                // A trap abandons the op and redirects like a RUN-state trap;
                // redirects from the frozen execute stage are not possible.
                if (i_trap) begin
                    o_mc_abort  = 1'b1;
                    o_pc_load   = 1'b1;
                    load_tgt    = i_trap_vec;
                    o_dec_flush = 1'b1;
                    o_ex_bubble = 1'b1;
                    state_d     = ST_FLUSH;
                    cnt_d       = FLUSH_LOAD;
                end else begin
                    o_fetch_stall = 1'b1;
                    o_dec_stall   = 1'b1;
                    if (i_ex_mc_done) begin
                        state_d = ST_RUN;
                    end else if (mc_timeout) begin
                        o_mc_abort = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                o_dec_flush = 1'b1;
                o_ex_bubble = 1'b1;
                if (i_trap || i_ex_redirect) begin
                    o_pc_load = 1'b1;
                    load_tgt  = i_trap ? i_trap_vec : i_ex_target;
                    cnt_d     = FLUSH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                o_fetch_stall = 1'b1;
                o_dec_flush   = 1'b1;
                o_ex_bubble   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
        pc_tgt_d    = o_pc_load ? load_tgt : pc_tgt_q;
        o_pc_target = pc_tgt_d;
    end

    // FSM state, shared counter and held redirect target
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= INIT_LOAD;
            pc_tgt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_tgt_q <= pc_tgt_d;
        end
    end

`ifdef RV_PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Stall cycles outside INIT and PC-load events, wrapping at 2^32
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (o_fetch_stall && (state_q != ST_INIT)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (o_pc_load) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign o_perf_stall_cnt = perf_stall_q;
    assign o_perf_flush_cnt = perf_flush_q;
`else
    assign o_perf_stall_cnt = '0;
    assign o_perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb_rv_pipe_ctrl: directed plus randomized checking of rv_pipe_ctrl
// against a behavioural model that tracks remaining init/flush cycles,
// an outstanding multicycle op and its elapsed wait time.
module tb_rv_pipe_ctrl;

    localparam int INIT_C  = 2;
    localparam int FLUSH_C = 2;
    localparam int MC_TO   = 8;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_imem_ready;
    logic [4:0]  i_dec_rs1, i_dec_rs2, i_ex_rd;
    logic        i_dec_rs1_use, i_dec_rs2_use;
    logic        i_ex_load, i_ex_mc_start, i_ex_mc_done, i_ex_redirect, i_trap;
    logic [29:0] i_ex_target, i_trap_vec;
    logic        o_fetch_stall, o_dec_stall, o_dec_flush, o_ex_bubble;
    logic        o_pc_load, o_mc_abort;
    logic [29:0] o_pc_target;
    logic [31:0] o_perf_stall_cnt, o_perf_flush_cnt;

    rv_pipe_ctrl #(
        .INIT_CYCLES (INIT_C),
        .FLUSH_CYCLES(FLUSH_C),
        .MC_TIMEOUT  (MC_TO)
    ) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_imem_ready    (i_imem_ready),
        .i_dec_rs1       (i_dec_rs1),
        .i_dec_rs2       (i_dec_rs2),
        .i_dec_rs1_use   (i_dec_rs1_use),
        .i_dec_rs2_use   (i_dec_rs2_use),
        .i_ex_rd         (i_ex_rd),
        .i_ex_load       (i_ex_load),
        .i_ex_mc_start   (i_ex_mc_start),
        .i_ex_mc_done    (i_ex_mc_done),
        .i_ex_redirect   (i_ex_redirect),
        .i_ex_target     (i_ex_target),
        .i_trap          (i_trap),
        .i_trap_vec      (i_trap_vec),
        .o_fetch_stall   (o_fetch_stall),
        .o_dec_stall     (o_dec_stall),
        .o_dec_flush     (o_dec_flush),
        .o_ex_bubble     (o_ex_bubble),
        .o_pc_load       (o_pc_load),
        .o_pc_target     (o_pc_target),
        .o_mc_abort      (o_mc_abort),
        .o_perf_stall_cnt(o_perf_stall_cnt),
        .o_perf_flush_cnt(o_perf_flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          init_left, flush_left, mc_waited;
    bit          mc_busy;
    logic [29:0] last_tgt;
    logic [31:0] m_stall, m_flush;

    // Expected outputs for the current cycle
    logic        e_fstall, e_dstall, e_flush, e_bubble, e_load, e_abort;
    logic [29:0] e_tgt, e_pc_target;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        init_left  = INIT_C;
        flush_left = 0;
        mc_busy    = 1'b0;
        mc_waited  = 0;
        last_tgt   = '0;
        m_stall    = '0;
        m_flush    = '0;
    endtask

    task automatic model_eval();
        bit lu;
        bit redir_or_trap;
        lu = i_ex_load && (i_ex_rd != 5'd0) &&
             ((i_dec_rs1_use && (i_dec_rs1 == i_ex_rd)) || (i_dec_rs2_use && (i_dec_rs2 == i_ex_rd)));
        redir_or_trap = i_trap || i_ex_redirect;
        {e_fstall, e_dstall, e_flush, e_bubble, e_load, e_abort} = '0;
        e_tgt = i_trap ? i_trap_vec : i_ex_target;
        if (init_left > 0) begin
            e_fstall = 1; e_flush = 1; e_bubble = 1;
        end else if (flush_left > 0) begin
            e_flush = 1; e_bubble = 1; e_load = redir_or_trap;
        end else if (mc_busy) begin
            if (i_trap) begin
                e_abort = 1; e_load = 1; e_flush = 1; e_bubble = 1;
            end else begin
                e_fstall = 1; e_dstall = 1;
                if (!i_ex_mc_done && MC_TO != 0 && mc_waited + 1 == MC_TO) e_abort = 1;
            end
        end else if (redir_or_trap) begin
            e_load = 1; e_flush = 1; e_bubble = 1;
        end else if (i_ex_mc_start && !i_ex_mc_done) begin
            e_fstall = 1; e_dstall = 1;
        end else if (lu || !i_imem_ready) begin
            e_fstall = 1; e_dstall = 1; e_bubble = 1;
        end
        e_pc_target = e_load ? e_tgt : last_tgt;
    endtask

    task automatic model_step();
`ifdef RV_PIPE_CTRL_PERF_EN
        if (e_fstall && init_left == 0) m_stall = m_stall + 32'd1;
        if (e_load) m_flush = m_flush + 32'd1;
`endif
        if (e_load) last_tgt = e_tgt;
        if (init_left > 0) begin
            init_left--;
        end else if (flush_left > 0) begin
            if (i_trap || i_ex_redirect) flush_left = FLUSH_C;
            else flush_left--;
        end else if (mc_busy) begin
            if (i_trap) begin
                mc_busy = 0; flush_left = FLUSH_C;
            end else if (i_ex_mc_done || (MC_TO != 0 && mc_waited + 1 == MC_TO)) begin
                mc_busy = 0;
            end else begin
                mc_waited++;
            end
        end else if (i_trap || i_ex_redirect) begin
            flush_left = FLUSH_C;
        end else if (i_ex_mc_start && !i_ex_mc_done) begin
            mc_busy = 1; mc_waited = 0;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_sc, exp_fc;
        model_eval();
`ifdef RV_PIPE_CTRL_PERF_EN
        exp_sc = m_stall; exp_fc = m_flush;
`else
        exp_sc = '0; exp_fc = '0;
`endif
        check_eq("fetch_stall", 32'(o_fetch_stall), 32'(e_fstall));
        check_eq("dec_stall",   32'(o_dec_stall),   32'(e_dstall));
        check_eq("dec_flush",   32'(o_dec_flush),   32'(e_flush));
        check_eq("ex_bubble",   32'(o_ex_bubble),   32'(e_bubble));
        check_eq("pc_load",     32'(o_pc_load),     32'(e_load));
        check_eq("pc_target",   32'(o_pc_target),   32'(e_pc_target));
        check_eq("mc_abort",    32'(o_mc_abort),    32'(e_abort));
        check_eq("perf_stall",  o_perf_stall_cnt,   exp_sc);
        check_eq("perf_flush",  o_perf_flush_cnt,   exp_fc);
    endtask

    // Called with inputs already driven (posedge+1); checks mid-cycle, then steps
    task automatic cycle();
        @(negedge i_clk);
        #1;
        check_outputs();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        i_imem_ready = 1; i_dec_rs1 = 0; i_dec_rs2 = 0; i_dec_rs1_use = 0; i_dec_rs2_use = 0;
        i_ex_rd = 0; i_ex_load = 0; i_ex_mc_start = 0; i_ex_mc_done = 0;
        i_ex_redirect = 0; i_ex_target = 0; i_trap = 0; i_trap_vec = 0;
    endtask

    task automatic do_reset();
        i_reset_n = 0;
        model_reset();
        #2;
        check_outputs();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset_n = 1;
    endtask

    task automatic rand_inputs();
        i_imem_ready  = ($urandom_range(0, 7) != 0);
        i_dec_rs1     = 5'($urandom_range(0, 3));
        i_dec_rs2     = 5'($urandom_range(0, 3));
        i_dec_rs1_use = 1'($urandom);
        i_dec_rs2_use = 1'($urandom);
        i_ex_rd       = 5'($urandom_range(0, 3));
        i_ex_load     = 1'($urandom);
        i_ex_mc_start = ($urandom_range(0, 7) == 0);
        i_ex_mc_done  = ($urandom_range(0, 5) == 0);
        i_ex_redirect = ($urandom_range(0, 9) == 0);
        i_ex_target   = 30'($urandom);
        i_trap        = ($urandom_range(0, 19) == 0);
        i_trap_vec    = 30'($urandom);
    endtask

    initial begin
        int cnt;
        idle_inputs();
        do_reset();

        // Init window: fetch stall + flush for exactly INIT_C cycles
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk); #1;
            if (o_fetch_stall && o_dec_flush) cnt++;
            check_outputs();
            @(posedge i_clk); model_step(); #1;
        end
        check_eq("init_len", 32'(cnt), 32'd2);

        // Load-use on rs2, then the rd=0 case
        i_ex_load = 1; i_ex_rd = 5; i_dec_rs2 = 5; i_dec_rs2_use = 1;
        @(negedge i_clk); #1;
        check_eq("lu_bubble", 32'(o_ex_bubble), 32'd1);
        check_outputs();
        @(posedge i_clk); model_step(); #1;
        i_ex_rd = 0; i_dec_rs2 = 0;
        @(negedge i_clk); #1;
        check_eq("lu_rd0", 32'(o_fetch_stall), 32'd0);
        check_outputs();
        @(posedge i_clk); model_step(); #1;
        idle_inputs();
        cycle();

        // Redirect, flush window, second redirect reloading the window
        i_ex_redirect = 1; i_ex_target = 30'h40;
        @(negedge i_clk); #1;
        check_eq("redir_tgt", 32'(o_pc_target), 32'h40);
        check_outputs();
        @(posedge i_clk); model_step(); #1;
        i_ex_redirect = 0;
        cycle();
        i_ex_redirect = 1; i_ex_target = 30'h123;
        cycle();
        i_ex_redirect = 0;
        repeat (4) cycle();

        // Multicycle completing after 7 wait cycles, then a timeout
        i_ex_mc_start = 1; cycle(); i_ex_mc_start = 0;
        repeat (6) cycle();
        i_ex_mc_done = 1; cycle(); i_ex_mc_done = 0;
        cycle();
        i_ex_mc_start = 1; cycle(); i_ex_mc_start = 0;
        cnt = 0;
        for (int k = 0; k < MC_TO + 2; k++) begin
            @(negedge i_clk); #1;
            if (o_mc_abort) cnt++;
            check_outputs();
            @(posedge i_clk); model_step(); #1;
        end
        check_eq("mc_abort_cnt", 32'(cnt), 32'd1);

        // Trap during MC_WAIT with a simultaneous redirect
        i_ex_mc_start = 1; cycle(); i_ex_mc_start = 0;
        cycle();
        i_trap = 1; i_trap_vec = 30'h40; i_ex_redirect = 1; i_ex_target = 30'h999;
        @(negedge i_clk); #1;
        check_eq("trap_abort", 32'({o_mc_abort, o_pc_load}), 32'd3);
        check_outputs();
        @(posedge i_clk); model_step(); #1;
        idle_inputs();
        repeat (3) cycle();

`ifdef RV_PIPE_CTRL_PERF_EN
        do_reset();
        repeat (3) cycle();
        for (int k = 0; k < 3; k++) begin
            i_ex_load = 1; i_ex_rd = 7; i_dec_rs1 = 7; i_dec_rs1_use = 1;
            cycle();
            idle_inputs();
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            i_ex_redirect = 1; i_ex_target = 30'h80;
            cycle();
            idle_inputs();
            repeat (3) cycle();
        end
        check_eq("perf_stall3", o_perf_stall_cnt, 32'd3);
        check_eq("perf_flush2", o_perf_flush_cnt, 32'd2);
        force dut.perf_stall_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_stall_q;
        m_stall = 32'hFFFF_FFFF;
        i_ex_load = 1; i_ex_rd = 7; i_dec_rs1 = 7; i_dec_rs1_use = 1;
        cycle();
        idle_inputs();
        check_eq("perf_wrap", o_perf_stall_cnt, 32'd0);
        cycle();
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                idle_inputs();
                do_reset();
            end
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_pipe_ctrl.md
Name: rv_pipe_ctrl

Overview:
Central pipeline sequencer for the in-order RV32 core.
- Generates stall/flush/bubble controls for the fetch stage, the decode/ucode stage register and the execute issue point.
- Drives the PC redirect for taken branches and traps.
- Sequences post-reset and post-redirect flush windows, load-use interlocks and multicycle (mul/div) waits from one FSM, so no stage computes its own hazards.

Parameters:
INIT_CYCLES, 2, cycles of forced flush after reset release (>=1)
FLUSH_CYCLES, 2, cycles decode stays flushed after a redirect; covers the decode stage's one-cycle delayed flush (>=1)
MC_TIMEOUT, 64, max MC_WAIT cycles before forced abort; 0 disables the timeout

Ports:
i_clk  in  1  core clock
i_reset_n  in  1  asynchronous active-low reset
i_imem_ready  in  1  fetch data valid this cycle
i_dec_rs1  in  5  decode-stage rs1 index
i_dec_rs2  in  5  decode-stage rs2 index
i_dec_rs1_use  in  1  decode instruction reads rs1
i_dec_rs2_use  in  1  decode instruction reads rs2
i_ex_rd  in  5  execute-stage rd index
i_ex_load  in  1  execute instruction is a load
i_ex_mc_start  in  1  multicycle op issued in execute this cycle
i_ex_mc_done  in  1  multicycle unit result ready
i_ex_redirect  in  1  taken branch/jump resolved in execute
i_ex_target  in  30  redirect target [31:2]
i_trap  in  1  trap request
i_trap_vec  in  30  trap vector [31:2]
o_fetch_stall  out  1  hold PC/fetch
o_dec_stall  out  1  hold decode register
o_dec_flush  out  1  clear decode register
o_ex_bubble  out  1  issue NOP into execute
o_pc_load  out  1  load o_pc_target into PC
o_pc_target  out  30  redirect address [31:2]
o_mc_abort  out  1  one-cycle pulse: multicycle op abandoned
o_perf_stall_cnt  out  32  stall-cycle counter (optional feature)
o_perf_flush_cnt  out  32  flush-event counter (optional feature)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (i_clk, i_reset_n).
  - While i_reset_n=0: state=INIT, counter=INIT_CYCLES-1.
  - Outputs: o_fetch_stall=1, o_dec_flush=1, o_ex_bubble=1, o_dec_stall=0, o_pc_load=0, o_pc_target=0, o_mc_abort=0, perf counters=0.
- States: INIT, RUN, MC_WAIT, FLUSH. Outputs are combinational from state plus current inputs. State and counters are registered.
- INIT:
  - Outputs as in reset.
  - Counter decrements each cycle; at 0, next state is RUN.
  - Redirect and trap are ignored.
- RUN priority, highest first:
  1. i_trap: o_pc_load=1, o_pc_target=i_trap_vec, o_dec_flush=1, o_ex_bubble=1; next FLUSH with counter=FLUSH_CYCLES-1.
  2. i_ex_redirect: as trap but o_pc_target=i_ex_target.
  3. i_ex_mc_start with i_ex_mc_done=0: o_fetch_stall=1, o_dec_stall=1; next MC_WAIT. If i_ex_mc_done=1 in the same cycle, no wait.
  4. Load-use: condition is i_ex_load, i_ex_rd!=0, and either (i_dec_rs1_use and rs1==rd) or (i_dec_rs2_use and rs2==rd). Response: o_fetch_stall=1, o_dec_stall=1, o_ex_bubble=1. Stays in RUN; exactly one cycle for a single load.
  5. i_imem_ready=0: o_fetch_stall=1, o_dec_stall=1, o_ex_bubble=1.
  6. Otherwise all controls 0.
- MC_WAIT:
  - o_fetch_stall=1, o_dec_stall=1, o_ex_bubble=0.
  - i_ex_mc_done=1: next RUN; stalls drop in the following cycle.
  - i_trap (higher priority than done): o_mc_abort=1, PC load to i_trap_vec, flush as in RUN; next FLUSH.
  - If MC_TIMEOUT!=0 and MC_TIMEOUT cycles elapse in MC_WAIT: o_mc_abort=1; next RUN.
  - i_ex_redirect is ignored in MC_WAIT; execute is frozen.
- FLUSH:
  - o_dec_flush=1, o_ex_bubble=1, o_fetch_stall=0.
  - Counter decrements; at 0, next RUN.
  - A trap or redirect arriving in FLUSH is accepted: PC load, counter reload to FLUSH_CYCLES-1.
- Async reset in any state: immediate return to INIT; any in-flight multicycle op is dropped without o_mc_abort.
- o_pc_target holds its last loaded value when o_pc_load=0.

Optional Feature:
RV_PIPE_CTRL_PERF_EN defined:
- o_perf_stall_cnt increments every cycle o_fetch_stall=1 outside INIT.
- o_perf_flush_cnt increments every cycle o_pc_load=1.
- Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
Undefined: both ports driven constant 0 and no counter flops are inferred.

Test Plan:
- Reset release, defaults: o_fetch_stall=o_dec_flush=1 for exactly 2 cycles after i_reset_n rises, then all controls 0 with i_imem_ready=1.
- Load-use: i_ex_load=1, i_ex_rd=5, i_dec_rs2=5, rs2_use=1 -> stall+bubble for 1 cycle. Same stimulus with rd=0 -> no stall.
- Redirect: i_ex_redirect=1, target=0x0000_0100 (>>2) -> o_pc_load=1 that cycle, then o_dec_flush=1 for 2 further cycles. A second redirect in the 1st flush cycle reloads the window.
- Multicycle: mc_start at cycle 10, mc_done at cycle 17 -> stalls asserted cycles 10-17, clear at 18. With MC_TIMEOUT=4 and no done -> o_mc_abort pulse after 4 wait cycles, back to RUN.
- Trap during MC_WAIT: i_trap=1, vec=0x40 -> o_mc_abort=1 and o_pc_load=1 in the same cycle, then FLUSH. With a simultaneous redirect, the trap wins.
- PERF_EN build: 3 load-use stalls + 2 redirects -> stall_cnt=3, flush_cnt=2. Preset the counter to 0xFFFFFFFF via force -> wraps to 0.
